// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate identifier: result codes, reference
// truth tables (bit index = {a,b}) and FSM state encoding.
package gate_pkg;

   typedef enum logic [2:0] {
      GC_UNKNOWN = 3'd0,
      GC_AND     = 3'd1,
      GC_OR      = 3'd2,
      GC_NAND    = 3'd3,
      GC_NOR     = 3'd4,
      GC_XOR     = 3'd5,
      GC_XNOR    = 3'd6,
      GC_NOT_A   = 3'd7
   } gate_code_e;

   localparam logic [3:0] TT_AND   = 4'b1000;
   localparam logic [3:0] TT_OR    = 4'b1110;
   localparam logic [3:0] TT_NAND  = 4'b0111;
   localparam logic [3:0] TT_NOR   = 4'b0001;
   localparam logic [3:0] TT_XOR   = 4'b0110;
   localparam logic [3:0] TT_XNOR  = 4'b1001;
   localparam logic [3:0] TT_NOT_A = 4'b0011;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_DECODE = 2'd2,
      S_DONE   = 2'd3
   } gi_state_e;

endpackage

// File: rtl/gate_decode.sv
// Combinational map from a captured 4-entry truth table to a gate code.
module gate_decode
   import gate_pkg::*;
(
   input  logic [3:0] truth,
   output logic [2:0] gate_code
);

   always_comb begin
      gate_code = GC_UNKNOWN;
      case (truth)
         TT_AND:   gate_code = GC_AND;
         TT_OR:    gate_code = GC_OR;
         TT_NAND:  gate_code = GC_NAND;
         TT_NOR:   gate_code = GC_NOR;
         TT_XOR:   gate_code = GC_XOR;
         TT_XNOR:  gate_code = GC_XNOR;
         TT_NOT_A: gate_code = GC_NOT_A;
         default:  gate_code = GC_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/gate_identifier.sv
// Drives all four input vectors into an attached 2-input gate, captures its
// response and publishes the truth table plus decoded gate type.
module gate_identifier
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       stim_a,
   output logic       stim_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth,
   output logic [2:0] gate_code
);

   localparam logic [3:0] SETTLE_C = SETTLE[3:0];

   gi_state_e  state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] hold_q, hold_d;
   logic [3:0] cap_q, cap_d;
   logic [3:0] truth_q, truth_d;
   logic [2:0] code_q, code_d;
   logic [2:0] dec_code;

   gate_decode u_decode (
      .truth     (cap_q),
      .gate_code (dec_code)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      cap_d   = cap_q;
      truth_d = truth_q;
      code_d  = code_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = 2'd0;
               hold_d  = 4'd0;
               cap_d   = 4'd0;
            end
         end
         S_DRIVE: begin
            // Sample on the last cycle of each hold so the gate has settled.
            if (hold_q == SETTLE_C) begin
               cap_d[idx_q] = dut_y;
               hold_d       = 4'd0;
               if (idx_q == 2'd3) begin
                  state_d = S_DECODE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         S_DECODE: begin
            state_d = S_DONE;
            truth_d = cap_q;
            code_d  = dec_code;
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         hold_q  <= 4'd0;
         cap_q   <= 4'd0;
         truth_q <= 4'd0;
         code_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         cap_q   <= cap_d;
         truth_q <= truth_d;
         code_q  <= code_d;
      end
   end

   assign stim_a    = (state_q == S_DRIVE) & idx_q[1];
   assign stim_b    = (state_q == S_DRIVE) & idx_q[0];
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign truth     = truth_q;
   assign gate_code = code_q;

endmodule
